hazard_scheduler: RTL and testbench

- Tracks in-flight destination registers across the ID, EXE and MEM pipeline stages of the 5-stage pipeline.
- Produces the registered 4-bit `depen` dependency vector consumed by the forwarding decoder in EXE.
- Produces a combinational load-use `stall` for the PC and IF/ID registers.
- Keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/hazard_scheduler_pkg.sv | 37 +++
 rtl/hazard_scheduler_reg_hit.sv | 16 +
 rtl/hazard_scheduler.sv | 104 ++++++++++
 tb/tb_hazard_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the ID/EXE/MEM hazard scheduler and the
// forwarding decoder that consumes its dependency vector.
package hazard_scheduler_pkg;

  localparam int REG_AW  = 5;
  localparam int DEPEN_W = 4;

  // Bit positions inside the depen vector
  localparam int DEP_RS_EXE = 3;
  localparam int DEP_RT_EXE = 2;
  localparam int DEP_RS_MEM = 1;
  localparam int DEP_RT_MEM = 0;

  // Operand-select encodings used by the forwarding decoder in EXE
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_ALT = 2'b01,
    FWD_EXE = 2'b10,
    FWD_MEM = 2'b11
  } fwd_sel_e;

  // Assemble depen with EXE-over-MEM priority: the youngest producer wins,
  // so a MEM hit is dropped whenever EXE also matches the same operand.
  function automatic logic [DEPEN_W-1:0] make_depen(input logic rs_exe,
                                                    input logic rt_exe,
                                                    input logic rs_mem,
                                                    input logic rt_mem);
    logic [DEPEN_W-1:0] d;
    d             = '0;
    d[DEP_RS_EXE] = rs_exe;
    d[DEP_RT_EXE] = rt_exe;
    d[DEP_RS_MEM] = rs_mem & ~rs_exe;
    d[DEP_RT_MEM] = rt_mem & ~rt_exe;
    return d;
  endfunction

endpackage

// File: rtl/hazard_scheduler_reg_hit.sv
// Single operand-vs-producer comparator. Register 0 is hard-wired to zero,
// so a producer targeting it never creates a dependency.
module reg_hit #(
  parameter int AW = 5
) (
  input  logic          valid_i,
  input  logic          use_i,
  input  logic          wreg_i,
  input  logic [AW-1:0] rd_i,
  input  logic [AW-1:0] src_i,
  output logic          hit_o
);

  assign hit_o = valid_i & use_i & wreg_i & (rd_i != '0) & (rd_i == src_i);

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard scheduler: shadows the destination registers in flight in EXE and
// MEM, produces the registered depen vector for EXE forwarding, a
// combinational load-use stall, and a saturating stall-cycle counter.
module hazard_scheduler #(
  parameter int REG_AW = hazard_scheduler_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              flush,
  output logic              stall,
  output logic [3:0]        depen,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hazard_scheduler_pkg::*;

  // EXE and MEM shadows of the instructions ahead of ID
  logic [REG_AW-1:0]  exe_rd_q, exe_rd_d;
  logic               exe_wreg_q, exe_wreg_d;
  logic               exe_m2reg_q, exe_m2reg_d;
  logic [REG_AW-1:0]  mem_rd_q;
  logic               mem_wreg_q;
  logic [3:0]         depen_q, depen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
  logic stall_c, bubble_c;

  reg_hit #(.AW(REG_AW)) u_exe_rs (
    .valid_i(id_valid), .use_i(id_use_rs), .wreg_i(exe_wreg_q),
    .rd_i(exe_rd_q), .src_i(id_rs), .hit_o(exe_hit_rs)
  );

  reg_hit #(.AW(REG_AW)) u_exe_rt (
    .valid_i(id_valid), .use_i(id_use_rt), .wreg_i(exe_wreg_q),
    .rd_i(exe_rd_q), .src_i(id_rt), .hit_o(exe_hit_rt)
  );

  reg_hit #(.AW(REG_AW)) u_mem_rs (
    .valid_i(id_valid), .use_i(id_use_rs), .wreg_i(mem_wreg_q),
    .rd_i(mem_rd_q), .src_i(id_rs), .hit_o(mem_hit_rs)
  );

  reg_hit #(.AW(REG_AW)) u_mem_rt (
    .valid_i(id_valid), .use_i(id_use_rt), .wreg_i(mem_wreg_q),
    .rd_i(mem_rd_q), .src_i(id_rt), .hit_o(mem_hit_rt)
  );

  // A load in EXE cannot forward yet; a taken branch kills the consumer anyway
  assign stall_c  = exe_m2reg_q & (exe_hit_rs | exe_hit_rt) & ~flush;
  assign bubble_c = stall_c | flush | ~id_valid;

  // Next EXE shadow, depen and counter values
  always_comb begin
    exe_rd_d    = id_rd;
    exe_wreg_d  = id_wreg;
    exe_m2reg_d = id_m2reg;
    depen_d     = make_depen(exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt);
    cnt_d       = cnt_q;
    if (bubble_c) begin
      exe_rd_d    = '0;
      exe_wreg_d  = 1'b0;
      exe_m2reg_d = 1'b0;
      depen_d     = '0;
    end
    if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Advance the shadows one stage per edge; reset clears every in-flight hit
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_rd_q    <= '0;
      exe_wreg_q  <= 1'b0;
      exe_m2reg_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      depen_q     <= '0;
      cnt_q       <= '0;
    end else begin
      mem_rd_q    <= exe_rd_q;
      mem_wreg_q  <= exe_wreg_q;
      exe_rd_q    <= exe_rd_d;
      exe_wreg_q  <= exe_wreg_d;
      exe_m2reg_q <= exe_m2reg_d;
      depen_q     <= depen_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall     = stall_c;
  assign depen     = depen_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a linear instruction sequence with
// expected depen values queued when each instruction is driven into ID and
// popped after the edge that moves it into EXE.
module tb_hazard_scheduler;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic          flush;
  logic          stall;
  logic [3:0]    depen;
  logic [CW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [3:0]    exp_q[$];
  logic [CW-1:0] exp_cnt;

  hazard_scheduler #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
    .stall(stall), .depen(depen), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ID cycle: drive at negedge, check stall, queue expected depen,
  // then compare depen just after the rising edge.
  task automatic step(input string tag, input logic v, input int rs, input int rt,
                      input logic urs, input logic urt, input int rd,
                      input logic wr, input logic ld, input logic fl,
                      input logic exp_stall, input logic [3:0] exp_depen);
    logic [3:0] e;
    @(negedge clk);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_use_rs = urs;
    id_use_rt = urt; id_rd = AW'(rd); id_wreg = wr; id_m2reg = ld; flush = fl;
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    exp_q.push_back(exp_depen);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".depen"}, 32'(depen), 32'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_rd = 0; id_wreg = 0; id_m2reg = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.depen", 32'(depen), 32'h0);
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    idle(3);
    check("idle.cnt", 32'(stall_cnt), 32'h0);

    // add r3 ; sub r4,r3,r5 -> EXE hit on rs
    step("add_r3", 1, 1, 2, 1, 1, 3, 1, 0, 0, 1'b0, 4'b0000);
    step("sub_exe", 1, 3, 5, 1, 1, 4, 1, 0, 0, 1'b0, 4'b1000);
    idle(2);

    // add r3 ; and r9 ; or r6,r2,r3 -> MEM hit on rt
    step("add_r3b", 1, 1, 2, 1, 1, 3, 1, 0, 0, 1'b0, 4'b0000);
    step("and_r9", 1, 10, 11, 1, 1, 9, 1, 0, 0, 1'b0, 4'b0000);
    step("or_mem", 1, 2, 3, 1, 1, 6, 1, 0, 0, 1'b0, 4'b0001);
    idle(2);

    // EXE beats MEM when both producers write r3
    step("add_r3c", 1, 1, 2, 1, 1, 3, 1, 0, 0, 1'b0, 4'b0000);
    step("add_r3d", 1, 1, 2, 1, 1, 3, 1, 0, 0, 1'b0, 4'b0000);
    step("prio", 1, 3, 3, 1, 1, 4, 1, 0, 0, 1'b0, 4'b1100);
    idle(2);

    // lw r7 ; add r8,r7,r7 -> one stall, then MEM forwarding on both operands
    step("lw_r7", 1, 1, 0, 1, 0, 7, 1, 1, 0, 1'b0, 4'b0000);
    step("lu_stall", 1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b1, 4'b0000);
    step("lu_after", 1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b0, 4'b0011);
    check("lu.cnt", 32'(stall_cnt), 32'h1);
    idle(2);

    // Flush on the dependent's ID cycle wins over the stall
    step("lw_r7f", 1, 1, 0, 1, 0, 7, 1, 1, 0, 1'b0, 4'b0000);
    step("flush", 1, 7, 7, 1, 1, 8, 1, 0, 1, 1'b0, 4'b0000);
    check("flush.cnt", 32'(stall_cnt), 32'h1);
    idle(2);

    // Writes to r0 never create dependencies
    step("add_r0", 1, 1, 2, 1, 1, 0, 1, 0, 0, 1'b0, 4'b0000);
    step("rd_r0a", 1, 0, 0, 1, 1, 5, 1, 0, 0, 1'b0, 4'b0000);
    step("rd_r0b", 1, 0, 0, 1, 1, 6, 1, 0, 0, 1'b0, 4'b0000);
    step("lw_r0", 1, 1, 0, 1, 0, 0, 1, 1, 0, 1'b0, 4'b0000);
    step("rd_r0c", 1, 0, 0, 1, 1, 6, 1, 0, 0, 1'b0, 4'b0000);
    idle(2);

    // 2^CW+3 load-use stalls: counter saturates at all-ones
    exp_cnt = 4'd1;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step("sat_lw", 1, 1, 0, 1, 0, 7, 1, 1, 0, 1'b0, 4'b0000);
      step("sat_stall", 1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b1, 4'b0000);
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      check("sat.cnt", 32'(stall_cnt), 32'(exp_cnt));
      step("sat_after", 1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b0, 4'b0011);
    end
    check("sat.final", 32'(stall_cnt), 32'hF);
    idle(2);

    // Reset asserted mid-stall clears everything; no stale hits afterwards
    step("rst_lw", 1, 1, 0, 1, 0, 7, 1, 1, 0, 1'b0, 4'b0000);
    @(negedge clk);
    id_valid = 1; id_rs = 7; id_rt = 7; id_use_rs = 1; id_use_rt = 1;
    id_rd = 8; id_wreg = 1; id_m2reg = 0; flush = 0; rst = 1'b1;
    #1;
    check("rst_mid.stall_pre", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    check("rst_mid.depen", 32'(depen), 32'h0);
    check("rst_mid.cnt", 32'(stall_cnt), 32'h0);
    check("rst_mid.stall_post", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("rst_after", 1, 7, 7, 1, 1, 8, 1, 0, 0, 1'b0, 4'b0000);
    check("rst_after.cnt", 32'(stall_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
